// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue scheduler.
//   - ALU opcode constants (4-bit ALU control codes)
//   - alu_op_supported(): 1 when the opcode is one the ALU implements
//   - state_t: scheduler FSM state encoding
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0100;
    localparam logic [3:0] ALU_XOR = 4'b0101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic alu_op_supported(input logic [3:0] op);
        return (op == ALU_AND) || (op == ALU_OR)  || (op == ALU_ADD) ||
               (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_XOR);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst_n   : clock, asynchronous active-low reset
//   valid[1:0]   : request lines
//   advance      : a grant was consumed this cycle; remember the winner
//   grant        : index of the winning requester (0 when nothing is valid)
//   grant_valid  : at least one requester is valid
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic       grant,
    output logic       grant_valid
);

    logic last_grant;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        grant = 1'b0;
        if (valid == 2'b11) begin
            grant = ~last_grant;
        end else begin
            grant = valid[1];
        end
    end

    assign grant_valid = |valid;

    // Resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (advance) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/alu_issue_sched.sv
// Shares one single-cycle combinational ALU between the execute stage
// (requester 0) and address generation (requester 1).
//   clk, rst_n                      : clock, asynchronous active-low reset
//   reqN_valid/ready/op/a/b         : requester N op handshake and payload
//   alu_control/operand_a/operand_b : registered drive to the ALU
//   alu_result, alu_zero            : ALU outputs, captured one cycle later
//   rsp_valid/ready/data/zero/id/err: response handshake and payload
//   busy                            : an op is in flight or a response is held
module alu_issue_sched
    import alu_pkg::*;
#(
    parameter int DW  = 32,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [OPW-1:0] req0_op,
    input  logic [DW-1:0]  req0_a,
    input  logic [DW-1:0]  req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [OPW-1:0] req1_op,
    input  logic [DW-1:0]  req1_a,
    input  logic [DW-1:0]  req1_b,
    output logic [OPW-1:0] alu_control,
    output logic [DW-1:0]  alu_operand_a,
    output logic [DW-1:0]  alu_operand_b,
    input  logic [DW-1:0]  alu_result,
    input  logic           alu_zero,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [DW-1:0]  rsp_data,
    output logic           rsp_zero,
    output logic           rsp_id,
    output logic           rsp_err,
    output logic           busy
);

    state_t          state, state_nx;
    logic            grant, grant_valid;
    logic            can_accept, accept;
    logic [OPW-1:0]  win_op;
    logic [DW-1:0]   win_a, win_b;
    logic [OPW-1:0]  op_q;
    logic [DW-1:0]   a_q, b_q;
    logic            id_q, err_q;
    logic [DW-1:0]   rsp_data_q;
    logic            rsp_zero_q, rsp_id_q, rsp_err_q;

    rr_arb2 u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid       ({req1_valid, req0_valid}),
        .advance     (accept),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign can_accept = (state == IDLE) || ((state == RESP) && rsp_ready);
    assign accept     = can_accept && grant_valid;
    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;

    assign win_op = grant ? req1_op : req0_op;
    assign win_a  = grant ? req1_a  : req0_a;
    assign win_b  = grant ? req1_b  : req0_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = EXEC;
            EXEC:    state_nx = RESP;
            RESP: begin
                if (rsp_ready) state_nx = accept ? EXEC : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand registers hold their value outside of an accept so the ALU
    // inputs stay quiet while idle or while a response is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            id_q  <= 1'b0;
            err_q <= 1'b0;
        end else if (accept) begin
            a_q  <= win_a;
            b_q  <= win_b;
            id_q <= grant;
            // Unsupported codes run as AND so the ALU output is harmless;
            // the response is forced to the error form at capture.
            if (alu_op_supported(win_op)) begin
                op_q  <= win_op;
                err_q <= 1'b0;
            end else begin
                op_q  <= ALU_AND;
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
            rsp_id_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else if (state == EXEC) begin
            rsp_data_q <= err_q ? '0 : alu_result;
            rsp_zero_q <= err_q ? 1'b1 : alu_zero;
            rsp_id_q   <= id_q;
            rsp_err_q  <= err_q;
        end
    end

    assign alu_control   = op_q;
    assign alu_operand_a = a_q;
    assign alu_operand_b = b_q;

    assign rsp_valid = (state == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state != IDLE);

endmodule
